// File: rtl/shift_loader_pkg.sv
// Shared state encoding for the shift_loader serializing load controller.
package shift_loader_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_SHIFT,
    S_CHECK
  } shift_loader_state_t;

endpackage

// File: rtl/shift_register.sv
// N-bit serial-in/parallel-out shift register; shifts data_in into the LSB.
module shift_register #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         data_in,
  output logic [N-1:0] q
);

  logic [N-1:0] q_reg;

  generate
    if (N == 1) begin : g_single
      always_ff @(posedge clk) begin
        if (rst)      q_reg <= '0;
        else if (ena) q_reg <= data_in;
      end
    end else begin : g_multi
      always_ff @(posedge clk) begin
        if (rst)      q_reg <= '0;
        else if (ena) q_reg <= {q_reg[N-2:0], data_in};
      end
    end
  endgenerate

  assign q = q_reg;

endmodule

// File: rtl/shift_loader.sv
// Accepts a parallel word, clears the attached shift register, shifts the word
// in MSB-first over N cycles, then reads the register back to confirm the load.
module shift_loader
  import shift_loader_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         sr_rst,
  output logic         sr_ena,
  output logic         sr_data,
  input  logic [N-1:0] sr_q,
  output logic         busy,
  output logic         done,
  output logic         match
);

  localparam int CW = $clog2(N + 1);

  shift_loader_state_t state_reg, state_next;
  logic [N-1:0]        word_q;
  logic [N-1:0]        word_ref;
  logic [CW-1:0]       cnt_reg;

  // Leaving SHIFT at cnt <= 1 also keeps the FSM from sticking if cnt is ever 0.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (in_valid) state_next = S_CLEAR;
      S_CLEAR: state_next = S_SHIFT;
      S_SHIFT: if (cnt_reg <= CW'(1)) state_next = S_CHECK;
      S_CHECK: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= S_IDLE;
      word_q    <= '0;
      word_ref  <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        S_IDLE: begin
          if (in_valid) begin
            word_q   <= in_data;
            word_ref <= in_data;
            cnt_reg  <= CW'(N);
          end
        end
        S_SHIFT: begin
          word_q <= word_q << 1;
          if (cnt_reg != '0) cnt_reg <= cnt_reg - CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready = (state_reg == S_IDLE);
  assign busy     = (state_reg != S_IDLE);
  assign sr_rst   = (state_reg == S_CLEAR);
  assign sr_ena   = (state_reg == S_SHIFT);
  assign sr_data  = (state_reg == S_SHIFT) && word_q[N-1];
  assign done     = (state_reg == S_CHECK);
  assign match    = (state_reg == S_CHECK) && (sr_q == word_ref);

endmodule

// File: tb/tb_shift_loader.sv
// Closed-loop bench: shift_loader driving a shift_register, checked cycle by cycle.
module tb_shift_loader;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         sr_rst, sr_ena, sr_data;
  logic [N-1:0] sr_q_raw;
  logic [N-1:0] sr_q;
  logic [N-1:0] stuck_mask;
  logic         busy, done, match;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stuck-at-1 fault injection on the readback path.
  assign sr_q = sr_q_raw | stuck_mask;

  shift_loader #(.N(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .sr_rst(sr_rst), .sr_ena(sr_ena), .sr_data(sr_data),
    .sr_q(sr_q), .busy(busy), .done(done), .match(match)
  );

  shift_register #(.N(N)) target (
    .clk(clk), .rst(sr_rst), .ena(sr_ena), .data_in(sr_data), .q(sr_q_raw)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, in_ready, 1);
    chk({tag, "_busy"},  busy,     0);
    chk({tag, "_srrst"}, sr_rst,   0);
    chk({tag, "_ena"},   sr_ena,   0);
    chk({tag, "_data"},  sr_data,  0);
    chk({tag, "_done"},  done,     0);
    chk({tag, "_match"}, match,    0);
  endtask

  // One complete transaction from the handshake cycle to the following IDLE cycle.
  // Reference: bit k of the serial stream is w[N-1-k]; readback is w plus any stuck bits.
  task automatic do_load(input logic [N-1:0] w, input logic [N-1:0] stuck,
                         input bit keep, input logic [N-1:0] nw, output int done_cyc);
    logic [N-1:0] exp_q;
    exp_q      = w | stuck;
    stuck_mask = stuck;
    in_valid   = 1'b1;
    in_data    = w;
    chk("hs_ready", in_ready, 1);
    chk("hs_busy",  busy,     0);
    tick;
    if (!keep) in_valid = 1'b0;
    chk("clr_srrst", sr_rst,   1);
    chk("clr_ena",   sr_ena,   0);
    chk("clr_busy",  busy,     1);
    chk("clr_ready", in_ready, 0);
    for (int k = 0; k < N; k++) begin
      tick;
      if (keep) in_data = nw;
      chk("sh_ena",   sr_ena,     1);
      chk("sh_bit",   sr_data,    w[N-1-k]);
      chk("sh_srrst", sr_rst,     0);
      chk("sh_done",  done,       0);
      chk("sh_ready", in_ready,   0);
    end
    tick;
    done_cyc = cyc;
    chk("ck_done",  done,     1);
    chk("ck_match", match,    exp_q == w);
    chk("ck_srq",   sr_q,     exp_q);
    chk("ck_ena",   sr_ena,   0);
    chk("ck_ready", in_ready, 0);
    tick;
    chk("end_ready", in_ready, 1);
    chk("end_done",  done,     0);
    chk("end_match", match,    0);
    chk("end_busy",  busy,     0);
    stuck_mask = '0;
    $display("load w=%b stuck=%b expect_match=%0d done_at=%0d", w, stuck, exp_q == w, done_cyc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int d1, d2, gap;
    bit have_pend, keep;
    logic [N-1:0] pend, w, nw, stuck;

    // Reset with in_valid asserted: must be ignored.
    rst = 1'b0; in_valid = 1'b1; in_data = 4'b0101; stuck_mask = '0;
    tick; tick;
    chk_idle("rst");
    in_valid = 1'b0; rst = 1'b1;
    tick;
    chk_idle("post_rst");

    // Basic load.
    do_load(4'b1010, 4'b0000, 1'b0, 4'b0000, d1);

    // Backpressure: word held, changed during SHIFT; next word taken at cycle 7.
    do_load(4'b0110, 4'b0000, 1'b1, 4'b1111, d1);
    do_load(4'b1111, 4'b0000, 1'b0, 4'b0000, d2);
    chk("bp_spacing", d2 - d1, 7);

    // Mismatch with readback bit 0 stuck at 1.
    do_load(4'b1000, 4'b0001, 1'b0, 4'b0000, d1);

    // Reset in the middle of SHIFT.
    in_valid = 1'b1; in_data = 4'b1111;
    tick;
    in_valid = 1'b0;
    tick; tick;
    chk("mid_ena", sr_ena, 1);
    rst = 1'b0;
    tick;
    rst = 1'b1;
    chk_idle("mid_rst");
    for (int i = 0; i < 8; i++) begin
      tick;
      chk("mid_nodone", done, 0);
      chk("mid_busy",   busy, 0);
    end
    do_load(4'b0001, 4'b0000, 1'b0, 4'b0000, d1);

    // Back-to-back with continuous in_valid.
    do_load(4'b1111, 4'b0000, 1'b1, 4'b0001, d1);
    do_load(4'b0001, 4'b0000, 1'b0, 4'b0000, d2);
    chk("b2b_spacing", d2 - d1, 7);

    // Randomized loads, idle gaps, held-valid chains and fault injection.
    have_pend = 1'b0;
    pend = '0;
    for (int i = 0; i < 24; i++) begin
      if (!have_pend) begin
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
          tick;
          chk("gap_ready", in_ready, 1);
          chk("gap_done",  done,     0);
        end
      end
      w     = have_pend ? pend : N'($urandom_range(0, 15));
      keep  = ($urandom_range(0, 1) == 1);
      nw    = N'($urandom_range(0, 15));
      stuck = (i % 4 == 3) ? N'(1 << $urandom_range(0, N - 1)) : '0;
      do_load(w, stuck, keep, nw, d2);
      if (have_pend) chk("rnd_spacing", d2 - d1, 7);
      d1 = d2;
      have_pend = keep;
      pend = nw;
    end
    if (have_pend) do_load(pend, 4'b0000, 1'b0, 4'b0000, d2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
